// File: rtl/stopwatch_bcd_if.sv
// rtl/stopwatch_bcd_if.sv - Stopwatch tick/button inputs and BCD display outputs
interface stopwatch_bcd_if;
   logic       tick_clk;
   logic       btn_start_stop;
   logic       btn_clear;
   logic       btn_lap;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
   logic [3:0] min_tens;
   logic       running;
   logic       lap_active;
   logic       overflow;

   modport master (
      output tick_clk, btn_start_stop, btn_clear, btn_lap,
      input  sec_ones, sec_tens, min_ones, min_tens, running, lap_active, overflow
   );

   modport slave (
      input  tick_clk, btn_start_stop, btn_clear, btn_lap,
      output sec_ones, sec_tens, min_ones, min_tens, running, lap_active, overflow
   );
endinterface

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - mm:ss BCD stopwatch counting synchronised 1 Hz tick edges
module stopwatch_bcd #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_MINUTES = 59
) (
   input  logic           clk_in,
   input  logic           rst_n,
   stopwatch_bcd_if.slave bus
);
   typedef enum logic [1:0] {STOPPED, RUNNING, FULL} state_t;

   localparam logic [3:0] MAX_MT = 4'(MAX_MINUTES / 10);
   localparam logic [3:0] MAX_MO = 4'(MAX_MINUTES % 10);

   // Each sync word is {lap, clear, start_stop, tick}; element 0 is the newest sample.
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [3:0]                  prev_q;
   logic [3:0]                  pulse;
   logic                        tick_p, ss_p, clr_p, lap_p;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] snap_q, snap_d;
   logic        lap_q, lap_d;
   logic [15:0] disp_q;
   logic        running_q, overflow_q;
   logic        at_max;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0],
                    {bus.btn_lap, bus.btn_clear, bus.btn_start_stop, bus.tick_clk}};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pulse  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign tick_p = pulse[0];
   assign ss_p   = pulse[1];
   assign clr_p  = pulse[2];
   assign lap_p  = pulse[3];

   assign at_max = (cnt_q == {MAX_MT, MAX_MO, 4'd5, 4'd9});

   function automatic logic [15:0] bcd_inc(input logic [15:0] c);
      logic [15:0] r;
      r = c;
      if (c[3:0] != 4'd9) begin
         r[3:0] = c[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (c[7:4] != 4'd5) begin
            r[7:4] = c[7:4] + 4'd1;
         end else begin
            r[7:4] = 4'd0;
            if (c[11:8] != 4'd9) begin
               r[11:8] = c[11:8] + 4'd1;
            end else begin
               r[11:8]  = 4'd0;
               r[15:12] = c[15:12] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      lap_d   = lap_q;
      if (clr_p) begin
         state_d = STOPPED;
         cnt_d   = '0;
         snap_d  = '0;
         lap_d   = 1'b0;
      end else begin
         case (state_q)
            STOPPED: if (ss_p) state_d = RUNNING;
            RUNNING: begin
               // Saturating tick wins over a coincident start_stop.
               if (tick_p && at_max) begin
                  state_d = FULL;
               end else begin
                  if (tick_p) cnt_d = bcd_inc(cnt_q);
                  if (ss_p)   state_d = STOPPED;
               end
            end
            default: ;
         endcase
         if (lap_p) begin
            if (lap_q) begin
               lap_d = 1'b0;
            end else if (state_q == RUNNING) begin
               snap_d = cnt_d;
               lap_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= STOPPED;
         cnt_q      <= '0;
         snap_q     <= '0;
         lap_q      <= 1'b0;
         disp_q     <= '0;
         running_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         snap_q     <= snap_d;
         lap_q      <= lap_d;
         disp_q     <= lap_d ? snap_d : cnt_d;
         running_q  <= (state_d == RUNNING);
         overflow_q <= (state_d == FULL);
      end
   end

   assign bus.sec_ones   = disp_q[3:0];
   assign bus.sec_tens   = disp_q[7:4];
   assign bus.min_ones   = disp_q[11:8];
   assign bus.min_tens   = disp_q[15:12];
   assign bus.running    = running_q;
   assign bus.lap_active = lap_q;
   assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - Self-checking bench for stopwatch_bcd (MAX_MINUTES 59 and 2)
module tb_stopwatch_bcd;
   localparam int SS      = 2;
   localparam int LAT     = SS + 1;
   localparam int ST_STOP = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_FULL = 2;

   typedef struct packed {
      int           total;
      int           snap;
      int           st;
      logic         lap;
      logic [LAT:0] ht;
      logic [LAT:0] hs;
      logic [LAT:0] hc;
      logic [LAT:0] hl;
   } mdl_t;

   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b0;
   logic        tick_r [2];
   logic        ss_r   [2];
   logic        clr_r  [2];
   logic        lap_r  [2];
   logic [15:0] o_dig  [2];
   logic [2:0]  o_flg  [2];
   mdl_t        m      [2];
   int          total_n = 0;
   int          bad_n   = 0;

   always #5 clk_in = ~clk_in;

   stopwatch_bcd_if sw0 ();
   stopwatch_bcd_if sw1 ();

   assign sw0.tick_clk       = tick_r[0];
   assign sw0.btn_start_stop = ss_r[0];
   assign sw0.btn_clear      = clr_r[0];
   assign sw0.btn_lap        = lap_r[0];
   assign sw1.tick_clk       = tick_r[1];
   assign sw1.btn_start_stop = ss_r[1];
   assign sw1.btn_clear      = clr_r[1];
   assign sw1.btn_lap        = lap_r[1];

   assign o_dig[0] = {sw0.min_tens, sw0.min_ones, sw0.sec_tens, sw0.sec_ones};
   assign o_dig[1] = {sw1.min_tens, sw1.min_ones, sw1.sec_tens, sw1.sec_ones};
   assign o_flg[0] = {sw0.running, sw0.lap_active, sw0.overflow};
   assign o_flg[1] = {sw1.running, sw1.lap_active, sw1.overflow};

   stopwatch_bcd #(.SYNC_STAGES(SS)) u_dut0 (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (sw0)
   );

   stopwatch_bcd #(.SYNC_STAGES(SS), .MAX_MINUTES(2)) u_dut1 (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (sw1)
   );

   function automatic int max_of(input int i);
      return (i == 0) ? 59 : 2;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      int mins;
      int secs;
      mins = v / 60;
      secs = v % 60;
      return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
   endfunction

   // Elapsed time held as plain seconds; an input rise takes effect LAT edges after it is first sampled.
   function automatic mdl_t step(input mdl_t x, input int maxm,
                                 input logic t, input logic s, input logic c, input logic l);
      mdl_t y;
      logic te, se, ce, le, was_run;
      y    = x;
      y.ht = {x.ht[LAT-1:0], t};
      y.hs = {x.hs[LAT-1:0], s};
      y.hc = {x.hc[LAT-1:0], c};
      y.hl = {x.hl[LAT-1:0], l};
      te   = y.ht[LAT-1] & ~y.ht[LAT];
      se   = y.hs[LAT-1] & ~y.hs[LAT];
      ce   = y.hc[LAT-1] & ~y.hc[LAT];
      le   = y.hl[LAT-1] & ~y.hl[LAT];
      if (ce) begin
         y.total = 0;
         y.snap  = 0;
         y.lap   = 1'b0;
         y.st    = ST_STOP;
      end else begin
         was_run = (x.st == ST_RUN);
         if (was_run) begin
            if (te && x.total == maxm * 60 + 59) begin
               y.st = ST_FULL;
            end else begin
               if (te) y.total = x.total + 1;
               if (se) y.st = ST_STOP;
            end
         end else if (x.st == ST_STOP && se) begin
            y.st = ST_RUN;
         end
         if (le) begin
            if (x.lap) begin
               y.lap = 1'b0;
            end else if (was_run) begin
               y.snap = y.total;
               y.lap  = 1'b1;
            end
         end
      end
      return y;
   endfunction

   initial begin
      m[0] = '0;
      m[1] = '0;
      forever begin
         @(posedge clk_in or negedge rst_n);
         for (int i = 0; i < 2; i++)
            m[i] = !rst_n ? '0 : step(m[i], max_of(i), tick_r[i], ss_r[i], clr_r[i], lap_r[i]);
      end
   end

   initial begin
      logic [15:0] exp_d;
      logic [2:0]  exp_f;
      forever begin
         @(negedge clk_in);
         if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
               exp_d = m[i].lap ? to_bcd(m[i].snap) : to_bcd(m[i].total);
               exp_f = {m[i].st == ST_RUN, m[i].lap, m[i].st == ST_FULL};
               total_n++;
               if (o_dig[i] !== exp_d) begin
                  bad_n++;
                  if (bad_n <= 20)
                     $display("FAIL cyc_digits[%0d] actual=%h required=%h", i, o_dig[i], exp_d);
               end
               total_n++;
               if (o_flg[i] !== exp_f) begin
                  bad_n++;
                  if (bad_n <= 20)
                     $display("FAIL cyc_flags[%0d] actual=%b required=%b", i, o_flg[i], exp_f);
               end
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total_n++;
      if (act != exp) begin
         bad_n++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic pulse(input int i, input logic t, input logic s, input logic c, input logic l);
      @(negedge clk_in);
      tick_r[i] = t;
      ss_r[i]   = s;
      clr_r[i]  = c;
      lap_r[i]  = l;
      idle(2);
      tick_r[i] = 1'b0;
      ss_r[i]   = 1'b0;
      clr_r[i]  = 1'b0;
      lap_r[i]  = 1'b0;
      idle(2);
   endtask

   task automatic ticks(input int i, input int n);
      repeat (n) pulse(i, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         tick_r[i] = 1'b0;
         ss_r[i]   = 1'b0;
         clr_r[i]  = 1'b0;
         lap_r[i]  = 1'b0;
      end
      idle(3);
      rst_n = 1'b1;
      idle(2);
      check("reset_digits", o_dig[0], 16'h0000);
      check("reset_flags", o_flg[0], 3'b000);

      pulse(0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("start_running", o_flg[0], 3'b100);

      @(negedge clk_in);
      tick_r[0] = 1'b1;
      @(posedge clk_in);
      @(posedge clk_in);
      #1 check("latency_edge2", o_dig[0], 16'h0000);
      @(posedge clk_in);
      #1 check("latency_edge3", o_dig[0], 16'h0001);
      @(negedge clk_in);
      tick_r[0] = 1'b0;
      idle(2);
      ticks(0, 4);
      check("five_ticks", o_dig[0], 16'h0005);
      check("five_ticks_flags", o_flg[0], 3'b100);

      ticks(0, 2);
      pulse(0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("run_tick_stop", o_dig[0], 16'h0008);
      check("run_tick_stop_flags", o_flg[0], 3'b000);
      pulse(0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("stop_tick_start", o_dig[0], 16'h0008);
      check("stop_tick_start_flags", o_flg[0], 3'b100);

      ticks(0, 2);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("lap_freeze", o_dig[0], 16'h0010);
      check("lap_freeze_flags", o_flg[0], 3'b110);
      ticks(0, 4);
      check("lap_held", o_dig[0], 16'h0010);
      check("model_internal_14", m[0].total, 14);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("lap_release", o_dig[0], 16'h0014);
      check("lap_release_flags", o_flg[0], 3'b100);

      ticks(0, 44);
      check("at_0058", o_dig[0], 16'h0058);
      check("model_58", m[0].total, 58);
      ticks(0, 1);
      check("at_0059", o_dig[0], 16'h0059);
      ticks(0, 1);
      check("at_0100", o_dig[0], 16'h0100);
      ticks(0, 1);
      check("at_0101", o_dig[0], 16'h0101);
      ticks(0, 538);
      check("at_0959", o_dig[0], 16'h0959);
      ticks(0, 1);
      check("at_1000", o_dig[0], 16'h1000);

      pulse(0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("clear", o_dig[0], 16'h0000);
      check("clear_flags", o_flg[0], 3'b000);
      pulse(0, 1'b0, 1'b1, 1'b0, 1'b0);
      ticks(0, 20);
      check("at_0020", o_dig[0], 16'h0020);
      pulse(0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("clear_wins", o_dig[0], 16'h0000);
      check("clear_wins_flags", o_flg[0], 3'b000);

      pulse(1, 1'b0, 1'b1, 1'b0, 1'b0);
      ticks(1, 179);
      check("max2_0259", o_dig[1], 16'h0259);
      check("max2_0259_flags", o_flg[1], 3'b100);
      ticks(1, 2);
      check("max2_hold", o_dig[1], 16'h0259);
      check("max2_full_flags", o_flg[1], 3'b001);
      pulse(1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("max2_start_ignored", o_flg[1], 3'b001);
      pulse(1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("max2_clear", o_dig[1], 16'h0000);
      check("max2_clear_flags", o_flg[1], 3'b000);

      pulse(0, 1'b0, 1'b1, 1'b0, 1'b0);
      pulse(1, 1'b0, 1'b1, 1'b0, 1'b0);
      ticks(0, 3);
      ticks(1, 2);
      check("pre_reset0", o_dig[0], 16'h0003);
      check("pre_reset1", o_dig[1], 16'h0002);
      @(negedge clk_in);
      tick_r[0] = 1'b1;
      @(posedge clk_in);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_dig0", o_dig[0], 16'h0000);
      check("async_rst_flg0", o_flg[0], 3'b000);
      check("async_rst_dig1", o_dig[1], 16'h0000);
      check("async_rst_flg1", o_flg[1], 3'b000);
      @(negedge clk_in);
      tick_r[0] = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(5);
      check("post_rst_dig0", o_dig[0], 16'h0000);
      check("post_rst_flg0", o_flg[0], 3'b000);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end
endmodule
